// File: rtl/noc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : noc_pkg                                                         |
// | Purpose  : Shared NoC link definitions: default VC count and flit width,   |
// |            flit type encoding, flit field offsets, and helpers to build a  |
// |            flit and a one-hot VC vector.                                   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package noc_pkg;

   localparam int VN     = 4;
   localparam int DW     = 32;
   localparam int MAX_VN = 8;
   localparam int MAX_DW = 64;

   typedef enum logic [1:0] {
      BODY   = 2'b00,
      HEAD   = 2'b01,
      TAIL   = 2'b10,
      SINGLE = 2'b11
   } flit_type_e;

   localparam int SEQ_LSB  = 0;
   localparam int VC_LSB   = 16;
   localparam int PORT_LSB = 19;
   localparam int TYPE_MSB = DW - 1;

   // Packet position of a flit is purely a function of its per-VC sequence.
   function automatic flit_type_e flit_type(input logic [15:0] seq, input int pkt_len);
      logic [15:0] pos;
      if (pkt_len == 1) return SINGLE;
      pos = seq % 16'(pkt_len);
      if (pos == 16'd0) return HEAD;
      if (pos == 16'(pkt_len - 1)) return TAIL;
      return BODY;
   endfunction

   // Built at the widest supported width; callers truncate to their DW.
   // type_msb is the caller's DW-1 so the type lands in the top two bits.
   function automatic logic [MAX_DW-1:0] make_flit(input logic [3:0]  port,
                                                   input logic [2:0]  vc,
                                                   input logic [15:0] seq,
                                                   input flit_type_e  ftype,
                                                   input int          type_msb);
      logic [MAX_DW-1:0] f;
      f                   = '0;
      f[SEQ_LSB  +: 16]   = seq;
      f[VC_LSB   +: 3]    = vc;
      f[PORT_LSB +: 4]    = port;
      f[type_msb -: 2]    = ftype;
      return f;
   endfunction

   function automatic logic [MAX_VN-1:0] onehot(input logic [2:0] idx);
      return MAX_VN'(1) << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Purpose  : Combinational round-robin arbiter. Priority starts at ptr and   |
// |            wraps; next_ptr is the slot after the winner when advance is    |
// |            set, otherwise ptr unchanged. The pointer register lives in the |
// |            parent so the arbiter can be shared by other allocators.        |
// | Ports    : req[N]        request vector                                    |
// |            advance       a grant is being consumed this cycle              |
// |            ptr           current highest-priority index                    |
// |            grant[N]      one-hot grant (zero when no request)              |
// |            grant_idx     binary index of the grant                         |
// |            next_ptr      pointer value for the next cycle                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic          advance,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic [IW-1:0] next_ptr
);

   int            w_k;
   logic [IW-1:0] w_kidx;
   logic          w_found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_k       = 0;
      w_kidx    = '0;
      for (int i = 0; i < N; i++) begin
         w_k = int'(ptr) + i;
         if (w_k >= N) w_k = w_k - N;
         w_kidx = IW'(w_k);
         if (!w_found && req[w_kidx]) begin
            w_found        = 1'b1;
            grant[w_kidx]  = 1'b1;
            grant_idx      = w_kidx;
         end
      end
      next_ptr = ptr;
      if (advance && w_found)
         next_ptr = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
   end

endmodule
`default_nettype wire

// File: rtl/vc_flit_injector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vc_flit_injector                                                |
// | Purpose  : Traffic source for one router input port. Emits FLITS_PER_VC    |
// |            flits on each VC, round-robin interleaved per flit, packetised  |
// |            as head/body/tail (or single when PKT_LEN is 1). Raises a       |
// |            sticky done once every VC's quota has been accepted.            |
// | Ports    : clk, rstn     clock, asynchronous active-low reset              |
// |            en_i          injection enable (gates new loads only)           |
// |            vc_o[VN]      one-hot VC of the presented flit                  |
// |            data_o[DW]    flit                                              |
// |            valid_o       flit valid; held until accepted                   |
// |            ready_i       downstream ready                                  |
// |            done          all VCs complete, sticky until reset              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vc_flit_injector #(
   parameter int PORT         = 0,
   parameter int VN           = noc_pkg::VN,
   parameter int DW           = noc_pkg::DW,
   parameter int FLITS_PER_VC = 1000,
   parameter int PKT_LEN      = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          en_i,
   output logic [VN-1:0] vc_o,
   output logic [DW-1:0] data_o,
   output logic          valid_o,
   input  logic          ready_i,
   output logic          done
);

   import noc_pkg::*;

   localparam int          IW      = (VN > 1) ? $clog2(VN) : 1;
   localparam logic [15:0] C_QUOTA = 16'(FLITS_PER_VC);

   logic [15:0]   r_seq [VN];
   logic [IW-1:0] r_ptr;
   logic [VN-1:0] r_vc;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          r_done;

   logic [VN-1:0] w_pending;
   logic [VN-1:0] w_grant;
   logic [IW-1:0] w_gidx;
   logic [IW-1:0] w_next_ptr;
   logic [2:0]    w_gidx_ext;
   logic [15:0]   w_seq_sel;
   logic          w_fire;
   logic          w_load;
   logic          w_all_sent;

   // seq advances at load time, so the VC held in the output register has
   // already moved past that flit; pending alone is the eligibility test.
   for (genvar v = 0; v < VN; v++) begin : g_pending
      assign w_pending[v] = (r_seq[v] < C_QUOTA);
   end

   assign w_fire     = r_valid & ready_i;
   assign w_load     = en_i & (|w_pending) & (~r_valid | w_fire);
   assign w_all_sent = ~(|w_pending);
   assign w_gidx_ext = 3'(w_gidx);
   assign w_seq_sel  = r_seq[w_gidx];

   rr_arbiter #(
      .N (VN)
   ) u_arb (
      .req       (w_pending),
      .advance   (w_load),
      .ptr       (r_ptr),
      .grant     (w_grant),
      .grant_idx (w_gidx),
      .next_ptr  (w_next_ptr)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_vc    <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_ptr   <= '0;
         for (int v = 0; v < VN; v++) r_seq[v] <= '0;
      end else begin
         r_ptr <= w_next_ptr;
         if (w_load) begin
            r_vc           <= w_grant;
            r_data         <= DW'(make_flit(4'(PORT), w_gidx_ext, w_seq_sel,
                                            flit_type(w_seq_sel, PKT_LEN), DW - 1));
            r_valid        <= 1'b1;
            r_seq[w_gidx]  <= w_seq_sel + 16'd1;
         end else if (w_fire) begin
            r_valid <= 1'b0;
         end
         // Last flit leaves on this edge (or nothing is left in flight).
         if (w_all_sent && (!r_valid || w_fire))
            r_done <= 1'b1;
      end
   end

   assign vc_o    = r_vc;
   assign data_o  = r_data;
   assign valid_o = r_valid;
   assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vc_flit_injector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vc_flit_injector                                             |
// | Purpose  : Self-checking bench for vc_flit_injector: a cycle-level         |
// |            reference model plus a per-VC fire scoreboard, with directed    |
// |            stall / enable-drop / mid-stream reset phases and a randomized  |
// |            ready/enable phase. A second instance covers PKT_LEN == 1.      |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vc_flit_injector;

   localparam int VN    = 4;
   localparam int DW    = 32;
   localparam int PORT  = 5;
   localparam int PKT   = 4;
   localparam int F     = 40;
   localparam int VN2   = 3;
   localparam int DW2   = 40;
   localparam int PORT2 = 2;
   localparam int F2    = 3;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic en   = 1'b0;
   logic ready = 1'b0;

   logic [VN-1:0]  vc;
   logic [DW-1:0]  data;
   logic           valid;
   logic           done;
   logic [VN2-1:0] vc2;
   logic [DW2-1:0] data2;
   logic           valid2;
   logic           done2;

   always #5 clk = ~clk;

   vc_flit_injector #(
      .PORT(PORT), .VN(VN), .DW(DW), .FLITS_PER_VC(F), .PKT_LEN(PKT)
   ) dut (
      .clk(clk), .rstn(rstn), .en_i(en), .vc_o(vc), .data_o(data),
      .valid_o(valid), .ready_i(ready), .done(done)
   );

   vc_flit_injector #(
      .PORT(PORT2), .VN(VN2), .DW(DW2), .FLITS_PER_VC(F2), .PKT_LEN(1)
   ) dut_single (
      .clk(clk), .rstn(rstn), .en_i(1'b1), .vc_o(vc2), .data_o(data2),
      .valid_o(valid2), .ready_i(1'b1), .done(done2)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int            m_seq [VN];
   int            m_ptr;
   bit            m_valid;
   bit            m_done;
   logic [VN-1:0] m_vcoh;
   logic [DW-1:0] m_data;

   // scoreboards
   int sb_next  [VN];
   int sb2_next [VN2];
   int fires;
   int done_rises;
   bit prev_done;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] exp_flit(input int v, input int s, input int pkt,
                                            input int port, input int dw);
      int t;
      if (pkt == 1)              t = 3;
      else if (s % pkt == 0)     t = 1;
      else if (s % pkt == pkt-1) t = 2;
      else                       t = 0;
      return (64'(t) << (dw - 2)) | (64'(port) << 19) | (64'(v) << 16) | 64'(s);
   endfunction

   // Advance the model by one clock using the inputs that the next edge sees.
   task automatic model_step();
      bit fire, pend;
      int w, c;
      if (!rstn) begin
         for (int v = 0; v < VN; v++) m_seq[v] = 0;
         m_ptr = 0; m_valid = 0; m_done = 0; m_vcoh = '0; m_data = '0;
         return;
      end
      fire = m_valid && ready;
      pend = 0;
      for (int v = 0; v < VN; v++) if (m_seq[v] < F) pend = 1;
      if (!pend && (!m_valid || fire)) m_done = 1;
      if (en && pend && (!m_valid || fire)) begin
         w = -1;
         for (int i = 0; i < VN; i++) begin
            c = (m_ptr + i) % VN;
            if (w < 0 && m_seq[c] < F) w = c;
         end
         m_vcoh   = VN'(1) << w;
         m_data   = DW'(exp_flit(w, m_seq[w], PKT, PORT, DW));
         m_valid  = 1;
         m_seq[w] = m_seq[w] + 1;
         m_ptr    = (w + 1) % VN;
      end else if (fire) begin
         m_valid = 0;
      end
   endtask

   task automatic score_main(input logic [VN-1:0] sv, input logic [DW-1:0] sd);
      int idx = 0;
      for (int v = 0; v < VN; v++) if (sv[v]) idx = v;
      chk("fire_onehot", 64'($onehot(sv)), 64'd1);
      chk("fire_vcfield", 64'(sd[18:16]), 64'(idx));
      chk("fire_flit", 64'(sd), exp_flit(idx, sb_next[idx], PKT, PORT, DW));
      sb_next[idx]++;
      fires++;
   endtask

   task automatic score_single(input logic [VN2-1:0] sv, input logic [DW2-1:0] sd);
      int idx = 0;
      for (int v = 0; v < VN2; v++) if (sv[v]) idx = v;
      chk("single_onehot", 64'($onehot(sv)), 64'd1);
      chk("single_type", 64'(sd[DW2-1 -: 2]), 64'd3);
      chk("single_flit", 64'(sd), exp_flit(idx, sb2_next[idx], 1, PORT2, DW2));
      sb2_next[idx]++;
   endtask

   task automatic tick();
      bit f, f2;
      logic [VN-1:0]  sv;
      logic [DW-1:0]  sd;
      logic [VN2-1:0] sv2;
      logic [DW2-1:0] sd2;
      f = rstn && valid && ready;  sv = vc;  sd = data;
      f2 = rstn && valid2;         sv2 = vc2; sd2 = data2;
      model_step();
      @(posedge clk);
      @(negedge clk);
      if (f)  score_main(sv, sd);
      if (f2) score_single(sv2, sd2);
      chk("valid_o", 64'(valid), 64'(m_valid));
      chk("vc_o",    64'(vc),    64'(m_vcoh));
      chk("data_o",  64'(data),  64'(m_data));
      chk("done",    64'(done),  64'(m_done));
      if (done && !prev_done) done_rises++;
      prev_done = done;
   endtask

   task automatic clear_sb();
      for (int v = 0; v < VN; v++)  sb_next[v] = 0;
      for (int v = 0; v < VN2; v++) sb2_next[v] = 0;
      fires = 0; done_rises = 0; prev_done = 0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      clear_sb();
   endtask

   task automatic run_until_done(input int budget, input bit rnd);
      int n = 0;
      while (!done && n < budget) begin
         if (rnd) begin
            ready = 1'($urandom % 2);
            en    = (($urandom % 10) != 0);
         end
         tick();
         n++;
      end
      if (!done) chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_complete();
      for (int v = 0; v < VN; v++)  chk("vc_count", 64'(sb_next[v]), 64'(F));
      for (int v = 0; v < VN2; v++) chk("single_count", 64'(sb2_next[v]), 64'(F2));
      chk("fires_total", 64'(fires), 64'(VN * F));
      chk("done_rises", 64'(done_rises), 64'd1);
      chk("done_single", 64'(done2), 64'd1);
   endtask

   initial begin
      clear_sb();
      @(negedge clk);
      // reset state
      repeat (3) tick();
      chk("reset_valid", 64'(valid), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      rstn = 1'b1;

      // full-rate streaming: zero-bubble, RR interleaving
      en = 1'b1; ready = 1'b1;
      run_until_done(2000, 1'b0);
      repeat (4) tick();
      check_complete();

      // stall after the 3rd fire, then enable drop while stalled
      do_reset();
      en = 1'b1; ready = 1'b1;
      for (int n = 0; n < 50 && fires < 3; n++) tick();
      ready = 1'b0;
      repeat (5) tick();
      ready = 1'b1;
      repeat (6) tick();
      ready = 1'b0;
      tick();
      en = 1'b0;
      repeat (3) tick();
      chk("hold_while_disabled", 64'(valid), 64'd1);
      ready = 1'b1;
      repeat (4) tick();
      chk("idle_when_disabled", 64'(valid), 64'd0);
      en = 1'b1;
      for (int n = 0; n < 50 && fires < 15; n++) tick();

      // mid-stream reset; restart from VC0 seq 0 HEAD
      rstn = 1'b0;
      tick();
      chk("valid_in_reset", 64'(valid), 64'd0);
      tick();
      rstn = 1'b1;
      clear_sb();
      tick();
      chk("first_after_reset", 64'(data), exp_flit(0, 0, PKT, PORT, DW));
      chk("first_vc_after_reset", 64'(vc), 64'd1);
      run_until_done(2000, 1'b0);
      repeat (2) tick();
      check_complete();

      // randomized ready / enable
      do_reset();
      run_until_done(20000, 1'b1);
      for (int n = 0; n < 20; n++) begin
         ready = 1'($urandom % 2);
         en    = 1'($urandom % 2);
         tick();
      end
      check_complete();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
